fnd_scan_ctrl: RTL and testbench
================================

Name: fnd_scan_ctrl

Overview:
Scan controller and segment driver for the 8-digit FND display path. It generates the 3-bit digit select that drives the upstream 8:1 nibble mux. It consumes the selected 4-bit nibble, decodes it to active-low 7-segment codes, and drives one registered anode at a time. A blanking gap between digits prevents ghosting.

Parameters:
P_SLOT_CLKS, 100000, clocks per digit slot (blank + show), 1 ms at 100 MHz; legal range P_SLOT_CLKS > P_BLANK_CLKS
P_BLANK_CLKS, 1000, clocks of anode-off blanking at the start of each slot; legal range >= 1

Ports:
i_clk  input  1  system clock, rising edge
i_reset_n  input  1  synchronous active-low reset
i_en  input  1  scan enable; 0 forces the display dark
i_digit  input  4  nibble from the digit mux for the current o_sel
i_digit_en  input  8  per-digit enable; bit k=0 keeps digit k dark
i_dp_mask  input  8  per-digit decimal point; bit k=1 lights DP on digit k
o_sel  output  3  digit select to the mux i_sel
o_an  output  8  anodes, active low, bit k = digit k
o_seg  output  7  segments, active low, {g,f,e,d,c,b,a}
o_dp  output  1  decimal point, active low
o_frame_tick  output  1  one-clock pulse when o_sel wraps 7->0

Behaviour:
- Interface: one clock i_clk; reset i_reset_n is synchronous and active-low. No async reset. All outputs are registered.
- Reset (i_reset_n=0 at posedge) sets the following; reset overrides everything, including mid-slot:
  - state=BLANK, cnt=0, o_sel=0
  - o_an=8'hFF, o_seg=7'h7F, o_dp=1, o_frame_tick=0
- FSM states: BLANK and SHOW. Counter cnt has width $clog2(P_SLOT_CLKS).
- BLANK:
  - o_an=8'hFF; cnt counts 0..P_BLANK_CLKS-1.
  - At cnt==P_BLANK_CLKS-1, on the next edge: state<=SHOW, cnt<=0, o_seg<=dec(i_digit), o_dp<=~i_dp_mask[o_sel].
  - On the same edge: o_an<= i_digit_en[o_sel] ? ~(8'b1<<o_sel) : 8'hFF.
- SHOW:
  - cnt counts 0..P_SLOT_CLKS-P_BLANK_CLKS-1. o_an, o_seg and o_dp hold.
  - At the last count: state<=BLANK, cnt<=0, o_an<=8'hFF, o_sel<=o_sel+1 (7 wraps to 0).
  - o_frame_tick<=1 for exactly that one clock, only on the 7->0 wrap; 0 otherwise.
- o_sel changes only on SHOW->BLANK, so the mux output has P_BLANK_CLKS clocks to settle.
- i_digit and i_dp_mask are sampled only on the BLANK->SHOW edge. Changes during SHOW or BLANK take effect in the next slot.
- o_seg/o_dp keep their last values during BLANK; they are invisible because the anodes are off.
- Slot period is exactly P_SLOT_CLKS clocks; frame period is 8*P_SLOT_CLKS clocks.
- i_en=0 at posedge: state<=BLANK, cnt<=0, o_an<=8'hFF, o_frame_tick<=0, o_sel held.
- i_en re-asserted: a full blank period, then SHOW of the held o_sel.
- Disabled digit (i_digit_en bit=0): slot timing and o_sel advance are unchanged; only the anode stays off.
- dec() table, hex to o_seg:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E

Test Plan:
- Use P_SLOT_CLKS=10, P_BLANK_CLKS=2, with a behavioural 8:1 mux model feeding i_digit from o_sel.
- Reset: hold i_reset_n=0 for 3 clocks, i_en=1, all enables 1 -> o_an=FF, o_seg=7F, o_dp=1, o_sel=0, o_frame_tick=0. After release: o_an=FF for 2 clocks, then o_an=FE for 8 clocks.
- Scan sequence: mux inputs 0..7 -> per slot o_an FE,FD,FB,F7,EF,DF,BF,7F each for 8 clocks, with FF for 2 clocks between. o_seg = 40,79,24,30,19,12,02,78.
- Frame tick: run 3 frames -> o_frame_tick high exactly 3 times, 80 clocks apart, each coincident with o_sel 7->0. Also check i_dp_mask=8'h01 -> o_dp=0 only in slot 0.
- Digit enable: i_digit_en=8'h0F -> slots 4..7 show o_an=FF, o_sel still cycles 0..7, period still 80.
- Sampling: change the i_digit source from 3 to F at the 4th SHOW clock of slot 3 -> o_seg stays 30 to slot end.
- Disruption, mid-SHOW at o_sel=5:
  - i_en=0 for 5 clocks -> o_an=FF next clock, o_sel stays 5; after re-enable, o_an=DF after 2 blank clocks.
  - Separately, i_reset_n=0 -> o_sel=0, o_an=FF next clock.

Source files
------------

// File: rtl/fnd_scan_ctrl_if.sv
// Display-side bundle between the FND scan controller and the digit mux / anode drivers.
// master = scan controller, slave = upstream mux + pins; no flow control, levels only.
interface fnd_scan_ctrl_if;
  logic       i_en;
  logic [3:0] i_digit;
  logic [7:0] i_digit_en;
  logic [7:0] i_dp_mask;
  logic [2:0] o_sel;
  logic [7:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp;
  logic       o_frame_tick;

  modport master (
    input  i_en, i_digit, i_digit_en, i_dp_mask,
    output o_sel, o_an, o_seg, o_dp, o_frame_tick
  );

  modport slave (
    output i_en, i_digit, i_digit_en, i_dp_mask,
    input  o_sel, o_an, o_seg, o_dp, o_frame_tick
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// 8-digit FND scanner: blank-then-show slots, hex to active-low 7-seg, one anode at a time.
// Latency: digit sampled at end of blank, visible next clock; no backpressure, free-running.
module fnd_scan_ctrl #(
  parameter int P_SLOT_CLKS  = 100000,
  parameter int P_BLANK_CLKS = 1000
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  fnd_scan_ctrl_if.master     bus
);

  localparam int CW = $clog2(P_SLOT_CLKS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(P_BLANK_CLKS - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(P_SLOT_CLKS - P_BLANK_CLKS - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    sel_q;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic [6:0]    seg_d;
  logic          dp_q;
  logic          tick_q;

  always_comb begin
    seg_d = 7'h7F;
    case (bus.i_digit)
      4'h0: seg_d = 7'h40;
      4'h1: seg_d = 7'h79;
      4'h2: seg_d = 7'h24;
      4'h3: seg_d = 7'h30;
      4'h4: seg_d = 7'h19;
      4'h5: seg_d = 7'h12;
      4'h6: seg_d = 7'h02;
      4'h7: seg_d = 7'h78;
      4'h8: seg_d = 7'h00;
      4'h9: seg_d = 7'h10;
      4'hA: seg_d = 7'h08;
      4'hB: seg_d = 7'h03;
      4'hC: seg_d = 7'h46;
      4'hD: seg_d = 7'h21;
      4'hE: seg_d = 7'h06;
      4'hF: seg_d = 7'h0E;
      default: seg_d = 7'h7F;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else if (!bus.i_en) begin
      // sel is held so re-enable resumes on the same digit after a full blank
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      an_q    <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
            seg_q   <= seg_d;
            dp_q    <= ~bus.i_dp_mask[sel_q];
            an_q    <= bus.i_digit_en[sel_q] ? ~(8'b1 << sel_q) : 8'hFF;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            an_q    <= 8'hFF;
            sel_q   <= sel_q + 3'd1;
            tick_q  <= (sel_q == 3'd7);
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_BLANK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.o_sel        = sel_q;
  assign bus.o_an         = an_q;
  assign bus.o_seg        = seg_q;
  assign bus.o_dp         = dp_q;
  assign bus.o_frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: timeline reference model compared every cycle, plus literal spot checks.
module tb_fnd_scan_ctrl;
  localparam int SLOT  = 10;
  localparam int BLANK = 2;

  localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [7:0] LIT_AN [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  localparam logic [6:0] LIT_SEG [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mux_src [8];
  int         n_chk = 0;
  int         n_err = 0;

  fnd_scan_ctrl_if bus ();

  // behavioural 8:1 mux feeding the digit back from the current select
  assign bus.i_digit = mux_src[bus.o_sel];

  fnd_scan_ctrl #(.P_SLOT_CLKS(SLOT), .P_BLANK_CLKS(BLANK)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: position in the run is the count of enabled edges since reset/disable;
  // slot = k / SLOT, offset = k % SLOT decides capture (end of blank) and advance (end of slot).
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_tick;
  logic [2:0] e_sel;
  int         m_k = 0;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    int pos;
    if (!rst_n) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_sel = 3'd0; e_tick = 1'b0;
      m_k = 0; m_live = 1'b1;
    end else if (m_live && !bus.i_en) begin
      e_an = 8'hFF; e_tick = 1'b0; m_k = 0;
    end else if (m_live) begin
      pos = m_k % SLOT;
      e_tick = 1'b0;
      if (pos == BLANK - 1) begin
        e_seg = DEC[mux_src[e_sel]];
        e_dp  = !bus.i_dp_mask[e_sel];
        e_an  = bus.i_digit_en[e_sel] ? ~(8'h01 << e_sel) : 8'hFF;
      end
      if (pos == SLOT - 1) begin
        e_an   = 8'hFF;
        e_tick = (e_sel == 3'd7);
        e_sel  = e_sel + 3'd1;
      end
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_an",   32'(bus.o_an),         32'(e_an));
      chk("m_seg",  32'(bus.o_seg),        32'(e_seg));
      chk("m_dp",   32'(bus.o_dp),         32'(e_dp));
      chk("m_sel",  32'(bus.o_sel),        32'(e_sel));
      chk("m_tick", 32'(bus.o_frame_tick), 32'(e_tick));
    end
  end

  task automatic wait_show(input logic [2:0] s);
    int n = 0;
    while (!(bus.o_sel == s && bus.o_an != 8'hFF) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout("wait_show");
  endtask

  task automatic wait_blank();
    int n = 0;
    while (bus.o_an != 8'hFF && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout("wait_blank");
  endtask

  task automatic wait_tick();
    int n = 0;
    while (bus.o_frame_tick !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout("wait_tick");
  endtask

  initial begin
    int nt, bad, tick_at;
    int t [3];
    logic [7:0] seen;
    logic [2:0] prev_sel;

    bus.i_en = 1'b1;
    bus.i_digit_en = 8'hFF;
    bus.i_dp_mask = 8'h00;
    for (int i = 0; i < 8; i++) mux_src[i] = 4'(i);

    // reset held for 3 clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an",   32'(bus.o_an),         32'h0FF);
    chk("rst_seg",  32'(bus.o_seg),        32'h07F);
    chk("rst_dp",   32'(bus.o_dp),         32'h1);
    chk("rst_sel",  32'(bus.o_sel),        32'h0);
    chk("rst_tick", 32'(bus.o_frame_tick), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("rel_an", 32'(bus.o_an), (i < 2) ? 32'h0FF : 32'h0FE);
    end

    // scan order and decode of digits 0..7
    for (int j = 0; j < 8; j++) begin
      wait_show(3'(j));
      chk("scan_an",  32'(bus.o_an),  32'(LIT_AN[j]));
      chk("scan_seg", 32'(bus.o_seg), 32'(LIT_SEG[j]));
      wait_blank();
    end

    // three frames: tick count, spacing and wrap alignment; DP only in slot 0
    wait_tick();
    bus.i_dp_mask = 8'h01;
    nt = 0;
    prev_sel = bus.o_sel;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (bus.o_frame_tick === 1'b1) begin
        if (nt < 3) t[nt] = i;
        nt++;
        chk("tick_sel",  32'(bus.o_sel), 32'h0);
        chk("tick_prev", 32'(prev_sel),  32'h7);
      end
      if (bus.o_an != 8'hFF) chk("dp_slot", 32'(bus.o_dp), (bus.o_sel == 3'd0) ? 32'h0 : 32'h1);
      prev_sel = bus.o_sel;
    end
    chk("tick_count", 32'(nt), 32'd3);
    if (nt == 3) begin
      chk("tick_gap1", 32'(t[1] - t[0]), 32'd80);
      chk("tick_gap2", 32'(t[2] - t[1]), 32'd80);
    end
    bus.i_dp_mask = 8'h00;

    // digits 4..7 disabled: dark anodes, unchanged select sequence and frame period
    bus.i_digit_en = 8'h0F;
    bad = 0; seen = 8'h00; tick_at = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      seen[bus.o_sel] = 1'b1;
      if (bus.o_sel >= 3'd4 && bus.o_an != 8'hFF) bad++;
      if (bus.o_frame_tick === 1'b1 && tick_at == 0) tick_at = i;
    end
    chk("den_dark",   32'(bad),     32'd0);
    chk("den_sels",   32'(seen),    32'h0FF);
    chk("den_period", 32'(tick_at), 32'd80);
    bus.i_digit_en = 8'hFF;

    // digit change mid-show is ignored until the next visit of that slot
    wait_show(3'd3);
    repeat (3) @(negedge clk);
    mux_src[3] = 4'hF;
    begin
      int n = 0;
      while (bus.o_an != 8'hFF && n < 20) begin
        chk("hold_seg", 32'(bus.o_seg), 32'h030);
        @(negedge clk);
        n++;
      end
      if (n >= 20) timeout("hold_seg");
    end
    wait_show(3'd3);
    chk("new_seg", 32'(bus.o_seg), 32'h00E);
    mux_src[3] = 4'h3;

    // enable dropped mid-show on digit 5 for 5 clocks
    wait_show(3'd5);
    repeat (2) @(negedge clk);
    bus.i_en = 1'b0;
    @(negedge clk);
    chk("dis_an",  32'(bus.o_an),  32'h0FF);
    chk("dis_sel", 32'(bus.o_sel), 32'h5);
    repeat (4) @(negedge clk);
    bus.i_en = 1'b1;
    @(negedge clk);
    chk("ren_blank", 32'(bus.o_an), 32'h0FF);
    @(negedge clk);
    chk("ren_an", 32'(bus.o_an), 32'h0DF);

    // reset mid-show on digit 5
    wait_show(3'd5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_sel", 32'(bus.o_sel), 32'h0);
    chk("mrst_an",  32'(bus.o_an),  32'h0FF);
    chk("mrst_seg", 32'(bus.o_seg), 32'h07F);
    rst_n = 1'b1;

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) mux_src[$urandom_range(7)] = 4'($urandom);
      if ($urandom_range(49) == 0) bus.i_dp_mask = 8'($urandom);
      if ($urandom_range(59) == 0) bus.i_digit_en = 8'($urandom);
      if (bus.i_en) begin
        if ($urandom_range(149) == 0) bus.i_en = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        bus.i_en = 1'b1;
      end
      rst_n = ($urandom_range(999) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
